// File: rtl/trndom_req_ctrl.sv
// Transmit-domain request controller: a small FIFO feeding a four-phase req/ack handshake.
// rack_trndom is the only asynchronous input and reaches the FSM through a flop chain.
module trndom_req_ctrl #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                          clk_trasnmit,
  input  logic                          rst_transmit,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_W-1:0]             s_data,
  output logic [DATA_W-1:0]             data_trndom,
  output logic                          tready,
  input  logic                          rack_trndom,
  output logic                          busy,
  output logic                          xfer_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [PtrW:0] LevelFull = (PtrW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StReq, StAckLow} state_e;

  logic [DATA_W-1:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]          level_q, level_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rack_s, push, pop, fifo_empty;

  state_e                 state_q;
  logic                   tready_q, xfer_done_q, busy_q;
  logic [DATA_W-1:0]      data_q;

  assign rack_s      = sync_q[SYNC_STAGES-1];
  assign fifo_empty  = (level_q == '0);
  // Depends only on the registered level, so a pop never reaches s_ready combinationally.
  assign s_ready     = (level_q != LevelFull);
  assign push        = s_valid && s_ready;

  assign data_trndom = data_q;
  assign tready      = tready_q;
  assign xfer_done   = xfer_done_q;
  assign busy        = busy_q;
  assign fifo_level  = level_q;

  always_comb begin
    pop = 1'b0;
    if (!fifo_empty && !rack_s && (state_q == StIdle || state_q == StAckLow)) begin
      pop = 1'b1;
    end
  end

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Storage carries no reset; entries are only read after being written.
  always_ff @(posedge clk_trasnmit) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

  always_ff @(posedge clk_trasnmit or negedge rst_transmit) begin
    if (!rst_transmit) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      sync_q   <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], rack_trndom};
      level_q <= level_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_trasnmit or negedge rst_transmit) begin
    if (!rst_transmit) begin
      state_q     <= StIdle;
      tready_q    <= 1'b0;
      xfer_done_q <= 1'b0;
      busy_q      <= 1'b0;
      data_q      <= '0;
    end else begin
      xfer_done_q <= 1'b0;
      unique case (state_q)
        StIdle, StAckLow: begin
          if (pop) begin
            data_q   <= mem_q[rd_ptr_q];
            tready_q <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= StReq;
          end else if (state_q == StAckLow && !rack_s) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        StReq: begin
          if (rack_s) begin
            tready_q    <= 1'b0;
            xfer_done_q <= 1'b1;
            state_q     <= StAckLow;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_trndom_req_ctrl.sv
// Directed bench for trndom_req_ctrl: the bench plays upstream source and receive-domain acker.
`timescale 1ns/1ps
module tb_trndom_req_ctrl;

  localparam int unsigned SyncStages = 2;

  logic        clk = 1'b0;
  logic        rst_transmit = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic [31:0] data_trndom;
  logic        tready;
  logic        rack_trndom = 1'b0;
  logic        busy;
  logic        xfer_done;
  logic [2:0]  fifo_level;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] tx_q[$];
  logic [31:0] exp_q[$];
  bit          up_en = 1'b0;
  int unsigned vgate = 100;
  bit          mon_en = 1'b0;
  int          low_cnt = 0;
  logic        tready_prev = 1'b0;

  trndom_req_ctrl #(
    .DATA_W      (32),
    .FIFO_DEPTH  (4),
    .SYNC_STAGES (SyncStages)
  ) dut (
    .clk_trasnmit (clk),
    .rst_transmit (rst_transmit),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .data_trndom  (data_trndom),
    .tready       (tready),
    .rack_trndom  (rack_trndom),
    .busy         (busy),
    .xfer_done    (xfer_done),
    .fifo_level   (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    if (tx_q.size() != 0 && $urandom_range(99) < vgate) begin
      s_valid = 1'b1;
      s_data  = tx_q[0];
    end else begin
      s_valid = 1'b0;
      s_data  = $urandom();
    end
  endtask

  // One clock; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    logic fire;
    fire = s_valid && s_ready;
    @(posedge clk);
    #1;
    if (up_en && fire) void'(tx_q.pop_front());
    if (mon_en) begin
      if (rack_trndom) low_cnt = 0;
      else low_cnt++;
      if (tready && !tready_prev) check("jit_rise_gap", 64'(low_cnt >= SyncStages + 1), 1);
      if (!tready && tready_prev) check("jit_fall_done", xfer_done, 1);
      if (xfer_done) begin
        if (exp_q.size() == 0) check("jit_extra_word", 1, 0);
        else check("jit_data", data_trndom, exp_q.pop_front());
      end
      check("jit_level", 64'(fifo_level <= 3'd4), 1);
      tready_prev = tready;
    end
    if (up_en) drive();
  endtask

  // Full four-phase exchange for one word; 'more' says another word is already queued.
  task automatic handshake(input string tag, input logic [31:0] exp, input bit more);
    int n = 0;
    while (!tready && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_req"}, tready, 1);
    check({tag, "_data"}, data_trndom, exp);
    tick();
    tick();
    check({tag, "_hold"}, data_trndom, exp);
    rack_trndom = 1'b1;
    tick();
    tick();
    check({tag, "_req_sync"}, tready, 1);
    tick();
    check({tag, "_req_fall"}, tready, 0);
    check({tag, "_done"}, xfer_done, 1);
    check({tag, "_data_keep"}, data_trndom, exp);
    rack_trndom = 1'b0;
    tick();
    check({tag, "_done_pulse"}, xfer_done, 0);
    tick();
    check({tag, "_acklow_busy"}, busy, 1);
    check({tag, "_acklow_req"}, tready, 0);
    tick();
    if (more) check({tag, "_b2b"}, {busy, tready}, 2'b11);
    else check({tag, "_idle"}, {busy, tready}, 2'b00);
  endtask

  initial begin
    // Reset
    #1 rst_transmit = 1'b0;
    #1;
    check("rst_tready", tready, 0);
    check("rst_data", data_trndom, 0);
    check("rst_done", xfer_done, 0);
    check("rst_busy", busy, 0);
    check("rst_level", fifo_level, 0);
    tick();
    tick();
    rst_transmit = 1'b1;
    tick();
    check("rst_s_ready", s_ready, 1);

    // Single word
    up_en = 1'b1;
    tx_q.push_back(32'hDEAD_BEEF);
    drive();
    tick();
    check("single_level", fifo_level, 1);
    check("single_early", tready, 0);
    tick();
    check("single_req", tready, 1);
    check("single_data", data_trndom, 32'hDEAD_BEEF);
    check("single_pop", fifo_level, 0);
    handshake("single", 32'hDEAD_BEEF, 1'b0);

    // Burst into a full FIFO
    for (int i = 1; i <= 6; i++) tx_q.push_back(32'(i));
    drive();
    for (int i = 0; i < 5; i++) tick();
    check("burst_level", fifo_level, 4);
    check("burst_s_ready", s_ready, 0);
    check("burst_req", tready, 1);
    check("burst_head", data_trndom, 1);

    // Upstream noise while full and in REQ must not disturb anything
    up_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'($urandom());
      s_data  = $urandom();
      tick();
      check("stable_data", data_trndom, 1);
      check("stable_level", fifo_level, 4);
    end
    up_en = 1'b1;
    drive();
    for (int i = 1; i <= 6; i++) handshake($sformatf("burst%0d", i), 32'(i), i < 6);

    // Stale acknowledge held across reset release
    rack_trndom  = 1'b1;
    rst_transmit = 1'b0;
    tick();
    tick();
    rst_transmit = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    tx_q.push_back(32'hA5);
    drive();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stale_hold", tready, 0);
    end
    check("stale_level", fifo_level, 1);
    rack_trndom = 1'b0;
    tick();
    check("stale_sync1", tready, 0);
    tick();
    check("stale_sync2", tready, 0);
    tick();
    check("stale_req", tready, 1);
    check("stale_data", data_trndom, 32'hA5);
    handshake("stale", 32'hA5, 1'b0);

    // Reset in the middle of a transfer
    tx_q.push_back(32'h11);
    tx_q.push_back(32'h22);
    tx_q.push_back(32'h33);
    drive();
    for (int i = 0; i < 3; i++) tick();
    check("mid_req", tready, 1);
    check("mid_level", fifo_level, 2);
    rst_transmit = 1'b0;
    tx_q.delete();
    s_valid = 1'b0;
    #1;
    check("mid_rst_req", tready, 0);
    check("mid_rst_data", data_trndom, 0);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_busy", busy, 0);
    tick();
    tick();
    rst_transmit = 1'b1;
    tick();
    tx_q.push_back(32'h77);
    drive();
    tick();
    tick();
    check("mid_new_req", tready, 1);
    check("mid_new_data", data_trndom, 32'h77);
    handshake("mid_new", 32'h77, 1'b0);

    // Asynchronous acknowledge phase with a throttled source
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] w;
      w = $urandom();
      tx_q.push_back(w);
      exp_q.push_back(w);
    end
    fork
      begin
        realtime d;
        forever begin
          @(posedge tready);
          d = 10.0 * $urandom_range(0, 2) + $urandom_range(2, 8) + 0.5;
          #d rack_trndom = 1'b1;
          @(negedge tready);
          d = 10.0 * $urandom_range(0, 2) + $urandom_range(2, 8) + 0.5;
          #d rack_trndom = 1'b0;
        end
      end
    join_none
    vgate       = 50;
    tready_prev = tready;
    low_cnt     = SyncStages + 1;
    mon_en      = 1'b1;
    drive();
    begin
      int cyc = 0;
      while (exp_q.size() != 0 && cyc < 40000) begin
        tick();
        cyc++;
      end
    end
    check("jit_drain", exp_q.size(), 0);
    mon_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/trndom_req_ctrl.md
# trndom_req_ctrl

Transmit-domain request controller that sits directly upstream of the half-handshake crossing. It accepts words from a local valid/ready stream into a small FIFO and presents them one at a time on `data_trndom`. For each word it raises `tready` and holds it until the receive domain's acknowledge `rack_trndom`, synchronized locally, completes a four-phase exchange. Everything runs on `clk_trasnmit`; `rack_trndom` is the only asynchronous input.

## Interface
- `DATA_W`, default 32: width of the data word.
- `FIFO_DEPTH`, default 4: number of FIFO entries; must be a power of 2 and at least 2.
- `SYNC_STAGES`, default 2: number of flops in the `rack_trndom` synchronizer; must be at least 2.

- `clk_trasnmit`, in, 1: the single clock.
- `rst_transmit`, in, 1: asynchronous, active-low reset.
- `s_valid`, in, 1: upstream word valid.
- `s_ready`, out, 1: FIFO can accept a word.
- `s_data`, in, `DATA_W`: upstream word.
- `data_trndom`, out, `DATA_W`: word presented to the crossing; registered.
- `tready`, out, 1: request level; registered.
- `rack_trndom`, in, 1: acknowledge from the receive domain; asynchronous.
- `busy`, out, 1: FSM is not in IDLE.
- `xfer_done`, out, 1: one-cycle pulse when a word has been acknowledged.
- `fifo_level`, out, clog2(`FIFO_DEPTH`)+1: number of occupied FIFO entries.

## Operation
**FIFO**
- A push occurs when `s_valid && s_ready`.
- `s_ready = (fifo_level != FIFO_DEPTH)`. It is derived only from registered count, with no combinational path from a pop.
- Read and write pointers are clog2(`FIFO_DEPTH`) bits and wrap naturally.
- Simultaneous push and pop leaves `fifo_level` unchanged.
- The head word is popped only by the FSM.

**Synchronizer**
- `rack_s` is the last stage of a `SYNC_STAGES`-flop chain on `rack_trndom`.
- The FSM uses only `rack_s`.

**FSM states: IDLE, REQ, ACK_LOW**
- **IDLE**
  - If the FIFO is non-empty and `rack_s == 0`: pop the head into `data_trndom`, set `tready <= 1`, go to REQ.
  - If `rack_s == 1` (for example, stale after reset), wait.
- **REQ**
  - `tready` and `data_trndom` are held stable.
  - On `rack_s == 1`: `tready <= 0`, `xfer_done <= 1` for one cycle, go to ACK_LOW.
- **ACK_LOW**
  - Wait for `rack_s == 0`.
  - Then, if the FIFO is non-empty, pop, set `tready <= 1`, and go to REQ directly.
  - Otherwise go to IDLE.
- `data_trndom` changes only on a pop. It keeps its last value in ACK_LOW and IDLE.
- No timeout exists: REQ waits for the acknowledge indefinitely.

**Reset** (asserted at any time, including mid-transfer)
- Outputs: `tready = 0`, `data_trndom = 0`, `xfer_done = 0`, `busy = 0`, `fifo_level = 0`, `s_ready = 1` once reset is released.
- State: the FIFO is emptied, the synchronizer flops are cleared, and the FSM returns to IDLE.
- An in-flight word is discarded.

## Timing
- **Accept to request:** a word accepted at edge E0 into an empty FIFO with the FSM in IDLE and `rack_s == 0` gives `tready = 1` and valid `data_trndom` after edge E0+1.
- **Acknowledge latency:** `rack_trndom` rising before edge R gives `rack_s = 1` after edge R+`SYNC_STAGES`-1. `tready` falls and `xfer_done` pulses after the following edge.
- **Back-to-back:** from `rack_s` falling, the next `tready` rise is one edge later. No IDLE cycle is inserted.
- **Throughput:** at most one word per full four-phase round trip.
- **FIFO full:** `s_ready = 0`. A push attempted while full is ignored and `fifo_level` stays `FIFO_DEPTH`.
- **FIFO empty:** the FSM stays in IDLE or ACK_LOW and `tready` remains 0.
- **Edge-case `fifo_level`:** if the FSM pops in the same cycle as a push into an empty FIFO, that cannot happen, because a pop needs registered non-empty. This gives the one-cycle first latency above.
- **Stability:** `busy` and `tready` are glitch-free registered outputs. `data_trndom` is stable for the whole time `tready = 1`.

## Test plan
- **Single word:** after reset, push 0xDEADBEEF.
  - `tready` rises one cycle later with `data_trndom = 0xDEADBEEF`.
  - Model `rack_trndom` high 3 cycles later: `tready` falls `SYNC_STAGES`+1 edges after the rack edge, and `xfer_done` pulses once.
  - Drop rack: `busy` goes 0.
- **Burst and full:** push 6 words 0x1..0x6 continuously while rack stays low.
  - Expected mid-sequence: `fifo_level` reaches 4 after one pop, `s_ready = 0`, and word 0x6 is held off upstream.
  - Complete the handshakes: all 6 words appear in order with 6 `xfer_done` pulses and no REQ→IDLE gaps.
- **Data stability:** toggle `s_data`/`s_valid` randomly while in REQ.
  - `data_trndom` must be unchanged until `tready` falls.
- **Stale acknowledge:** hold `rack_trndom = 1` through reset release, then push 0xA5.
  - `tready` stays 0 until rack has been low for `SYNC_STAGES` cycles.
  - Then `tready` rises with `data_trndom = 0xA5`.
- **Reset mid-transfer:** assert `rst_transmit` low in REQ with 2 words queued.
  - Immediately (asynchronously): `tready = 0`, `data_trndom = 0`, `fifo_level = 0`.
  - After release, a new push 0x77 is the first word presented.
- **Asynchronous rack jitter:** randomize the rack phase relative to the clock over 1000 transfers with a random `s_valid`.
  - The scoreboard must receive the exact input sequence, never see `tready` high in ACK_LOW, and never see `fifo_level` exceed 4.
